// File: rtl/sram_controller.sv
// sram_controller: splits each 32-bit memory-stage load/store into two
// sequential 16-bit accesses to an asynchronous SRAM.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   wrEn, rdEn          store / load request (write wins when both set)
//   address, writeData  byte address and store data
//   readData            registered load data (changes only on reads)
//   ready               low while a request is pending; high in DONE
//   sramDq              bidirectional SRAM data bus
//   sramAddr            SRAM half-word address
//   sramWeN/OeN/CeN     SRAM write / output / chip enables (active low)
//   sramUbN/LbN         byte enables, tied active
//
// Optional build macro SRAM_ADDR_OFFSET_EN: data memory is mapped at
// byte address 1024, so that offset is subtracted before indexing.
module sram_controller #(
    parameter int WAIT_CYCLES = 3,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wrEn,
    input  logic               rdEn,
    input  logic [31:0]        address,
    input  logic [31:0]        writeData,
    output logic [31:0]        readData,
    output logic               ready,
    inout  wire  [15:0]        sramDq,
    output logic [SRAM_AW-1:0] sramAddr,
    output logic               sramWeN,
    output logic               sramOeN,
    output logic               sramCeN,
    output logic               sramUbN,
    output logic               sramLbN
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [SRAM_AW-2:0] widx_q, widx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic               we_n_q, we_n_d;
    logic               oe_n_q, oe_n_d;
    logic               ce_n_q, ce_n_d;
    logic               dq_oe_q, dq_oe_d;
    logic [15:0]        dq_out_q, dq_out_d;

    logic [31:0] ea;
    logic        busy_n;
    logic        hi_n;
    logic        ea_unused;

`ifdef SRAM_ADDR_OFFSET_EN
    assign ea = address - 32'd1024;
`else
    assign ea = address;
`endif

    // Byte-lane and out-of-range address bits carry no information here.
    assign ea_unused = ^{ea[31:SRAM_AW+1], ea[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        widx_d  = widx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (wrEn | rdEn) begin
                    wr_d    = wrEn;
                    widx_d  = ea[SRAM_AW:2];
                    wdata_d = writeData;
                    cnt_d   = '0;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (cnt_q == LAST) begin
                    if (!wr_q) begin
                        rdata_d[15:0] = sramDq;
                    end
                    cnt_d   = '0;
                    state_d = S_HI;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_HI: begin
                if (cnt_q == LAST) begin
                    if (!wr_q) begin
                        rdata_d[31:16] = sramDq;
                    end
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus outputs are computed from the next state so the registered
    // copies line up with the state they belong to.
    always_comb begin
        busy_n   = (state_d == S_LO) || (state_d == S_HI);
        hi_n     = (state_d == S_HI);
        ce_n_d   = !busy_n;
        oe_n_d   = !(busy_n && !wr_d);
        // Release WE on the last cycle of each phase so the write pulse
        // ends before the address moves on.
        we_n_d   = !(busy_n && wr_d && (cnt_d != LAST));
        dq_oe_d  = busy_n && wr_d;
        dq_out_d = hi_n ? wdata_d[31:16] : wdata_d[15:0];
        addr_d   = busy_n ? {widx_d, hi_n} : addr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            widx_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            addr_q   <= '0;
            we_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            ce_n_q   <= 1'b1;
            dq_oe_q  <= 1'b0;
            dq_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            widx_q   <= widx_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
            we_n_q   <= we_n_d;
            oe_n_q   <= oe_n_d;
            ce_n_q   <= ce_n_d;
            dq_oe_q  <= dq_oe_d;
            dq_out_q <= dq_out_d;
        end
    end

    assign ready    = !(wrEn | rdEn) || (state_q == S_DONE);
    assign readData = rdata_q;
    assign sramAddr = addr_q;
    assign sramWeN  = we_n_q;
    assign sramOeN  = oe_n_q;
    assign sramCeN  = ce_n_q;
    assign sramUbN  = 1'b0;
    assign sramLbN  = 1'b0;
    assign sramDq   = dq_oe_q ? dq_out_q : 16'bz;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed + random loads/stores against a
// word-level reference memory and a simple asynchronous SRAM model.
module tb_sram_controller;

    localparam int WAIT = 3;
`ifdef SRAM_ADDR_OFFSET_EN
    localparam int OFS = 1024;
`else
    localparam int OFS = 0;
`endif

    logic        clk = 0;
    logic        rst;
    logic        wr, rd;
    logic [31:0] addr, wd;
    logic [31:0] rdata;
    logic        ready;
    wire  [15:0] dq;
    logic [17:0] saddr;
    logic        wen, oen, cen, ubn, lbn;

    logic        wr1, rd1;
    logic [31:0] addr1, wd1;
    logic [31:0] rdata1_unused;
    logic        ready1;
    wire  [15:0] dq1_unused;
    logic [17:0] saddr1_unused;
    logic        wen1_unused, oen1_unused, cen1_unused;
    logic        ubn1_unused, lbn1_unused;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem     [0:1023];
    logic [31:0] ref_mem [0:255];
    logic [31:0] exp_rd;

    always #5 clk = ~clk;

    sram_controller #(.WAIT_CYCLES(WAIT), .SRAM_AW(18)) dut (
        .clk(clk), .rst(rst), .wrEn(wr), .rdEn(rd),
        .address(addr), .writeData(wd),
        .readData(rdata), .ready(ready), .sramDq(dq),
        .sramAddr(saddr), .sramWeN(wen), .sramOeN(oen),
        .sramCeN(cen), .sramUbN(ubn), .sramLbN(lbn)
    );

    sram_controller #(.WAIT_CYCLES(1), .SRAM_AW(18)) dut1 (
        .clk(clk), .rst(rst), .wrEn(wr1), .rdEn(rd1),
        .address(addr1), .writeData(wd1),
        .readData(rdata1_unused), .ready(ready1),
        .sramDq(dq1_unused), .sramAddr(saddr1_unused),
        .sramWeN(wen1_unused), .sramOeN(oen1_unused),
        .sramCeN(cen1_unused), .sramUbN(ubn1_unused),
        .sramLbN(lbn1_unused)
    );

    // Asynchronous SRAM: drives while selected and output-enabled,
    // latches data when the write pulse closes.
    assign dq = (oen === 1'b0 && cen === 1'b0) ? mem[saddr[9:0]] : 16'bz;

    always @(posedge wen) begin
        if (cen === 1'b0) mem[saddr[9:0]] = dq;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic op(input bit w, input bit r, input int widx,
                      input logic [31:0] data);
        int  lows;
        int  wlow;
        bit  seen;
        bit  bus_ok;
        lows = 0;
        wlow = 0;
        seen = 0;
        bus_ok = 1;
        @(negedge clk);
        wr = w;
        rd = r;
        addr = 32'(OFS + widx * 4);
        wd = data;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (ready) begin
                seen = 1;
                break;
            end
            lows++;
            if (wen === 1'b0) wlow++;
            if (lows > 1) begin
                if (cen !== 1'b0) bus_ok = 0;
                if (w) begin
                    if (oen !== 1'b1) bus_ok = 0;
                end else if (wen !== 1'b1 || oen !== 1'b0) begin
                    bus_ok = 0;
                end
            end
            @(negedge clk);
        end
        chk("ready_seen", 32'(seen), 1);
        chk("frozen_cycles", lows, 2 * WAIT + 1);
        chk("bus_ctrl", 32'(bus_ok), 1);
        chk("we_low_cycles", wlow, w ? 2 * (WAIT - 1) : 0);
        if (w) ref_mem[widx] = data;
        else exp_rd = ref_mem[widx];
        chk("read_data", rdata, exp_rd);
        wr = 0;
        rd = 0;
        if (w) begin
            chk("sram_lo", 32'(mem[2 * widx]), 32'(data[15:0]));
            chk("sram_hi", 32'(mem[2 * widx + 1]), 32'(data[31:16]));
        end
    endtask

    initial begin
        int  lows1;
        bit  seen1;
        int  kind;
        int  widx;

        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        exp_rd = '0;
        rst = 1;
        wr = 0; rd = 0; addr = 0; wd = 0;
        wr1 = 0; rd1 = 0; addr1 = 0; wd1 = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        #1;
        chk("rst_rdata", rdata, 0);
        chk("rst_wen", 32'(wen), 1);
        chk("rst_oen", 32'(oen), 1);
        chk("rst_cen", 32'(cen), 1);
        chk("rst_addr", 32'(saddr), 0);
        chk("rst_ready", 32'(ready), 1);
        chk("ub_lb", 32'({ubn, lbn}), 0);

        op(1, 0, 2, 32'hDEADBEEF);
        op(0, 1, 2, 0);
        op(1, 0, 3, 32'h12345678);
        op(0, 1, 2, 0);
        op(0, 1, 3, 0);
        op(1, 1, 5, 32'hCAFEF00D);
        op(0, 1, 5, 0);

        // Reset in the middle of the low phase of a store.
        @(negedge clk);
        wr = 1;
        addr = 32'(OFS + 7 * 4);
        wd = 32'hA5A5_5A5A;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1;
        #1;
        chk("midrst_wen", 32'(wen), 1);
        chk("midrst_cen", 32'(cen), 1);
        chk("midrst_rdata", rdata, 0);
        exp_rd = '0;
        @(negedge clk);
        rst = 0;
        wr = 0;
        #1;
        chk("midrst_ready", 32'(ready), 1);
        @(negedge clk);
        #1;
        chk("post_rst_cen", 32'(cen), 1);
        op(1, 0, 7, 32'h0BAD_F00D);
        op(0, 1, 7, 0);

        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 2));
            widx = int'($urandom_range(0, 255));
            unique case (kind)
                0: op(1, 0, widx, $urandom);
                1: op(0, 1, widx, 0);
                default: op(1, 1, widx, $urandom);
            endcase
        end

        for (int k = 0; k < 4; k++) begin
            lows1 = 0;
            seen1 = 0;
            @(negedge clk);
            wr1 = (k % 2 == 0);
            rd1 = (k % 2 == 1);
            addr1 = 32'(OFS + k * 4);
            wd1 = $urandom;
            for (int i = 0; i < 20; i++) begin
                #1;
                if (ready1) begin
                    seen1 = 1;
                    break;
                end
                lows1++;
                @(negedge clk);
            end
            chk("w1_ready_seen", 32'(seen1), 1);
            chk("w1_frozen", lows1, 3);
            wr1 = 0;
            rd1 = 0;
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle controller between the memory stage and the off-chip 16-bit asynchronous SRAM. It replaces the single-cycle data memory behind the memory stage. Each 32-bit word load or store becomes two sequential 16-bit SRAM accesses. The block holds `ready` low until the access completes, and the pipeline uses `~ready` as its freeze signal.

## Interface
Parameters:
- `WAIT_CYCLES`, 3: cycles each 16-bit half-access is held on the SRAM bus (legal 1..15).
- `SRAM_AW`, 18: SRAM address width in half-words.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wrEn` in 1: store request from the memory stage.
- `rdEn` in 1: load request from the memory stage.
- `address` in 32: byte address (ALU result).
- `writeData` in 32: store data (valRm).
- `readData` out 32: registered load data.
- `ready` out 1: high when no request is pending or the current request completes this cycle.
- `sramDq` inout 16: SRAM data bus.
- `sramAddr` out SRAM_AW: SRAM half-word address.
- `sramWeN` out 1: SRAM write enable, active low.
- `sramOeN` out 1: SRAM output enable, active low.
- `sramCeN` out 1: SRAM chip enable, active low.
- `sramUbN` out 1: upper byte enable, active low, tied 0.
- `sramLbN` out 1: lower byte enable, active low, tied 0.

## Operation
- Effective byte address `ea` = `address` (see Configuration). Word index = `ea[SRAM_AW:2]`.
- Half-word addressing:
  - Low half: `sramAddr = {wordIdx, 1'b0}`.
  - High half: `sramAddr = {wordIdx, 1'b1}`.
- FSM states: IDLE, LO, HI, DONE. A `WAIT_CYCLES`-wide counter runs in LO and HI.
- IDLE:
  - If `wrEn|rdEn`, latch op (write if `wrEn`; write wins when both are asserted), latch address and data, clear the counter, go to LO.
  - Otherwise stay in IDLE.
- LO: drive low half. At counter == WAIT_CYCLES-1, capture `sramDq` into `readData[15:0]` (reads only), clear the counter, go to HI.
- HI: same for the high half into `readData[31:16]`, then go to DONE.
- DONE: `ready`=1 for exactly one cycle, then IDLE unconditionally.
- Writes:
  - `sramWeN`=0 throughout LO/HI, except on the final counter cycle of each phase, where it is 1. This closes the write pulse before the address changes.
  - `sramDq` is driven with the latched half only in LO/HI of a write; otherwise it is high-Z.
- Reads: `sramOeN`=0 in LO/HI, `sramWeN`=1, `sramDq` high-Z.
- `sramCeN`=0 in LO/HI, 1 otherwise.
- `readData`:
  - Updates only in read phases.
  - Holds its last value across writes and idle cycles.
  - A write never alters `readData`.
- `ready`:
  - Combinational `ready = ~(wrEn|rdEn) | (state==DONE)`.
  - The pipeline holds `wrEn`/`rdEn`/`address`/`writeData` stable while `ready`=0.
  - Input changes during LO/HI are ignored (latched copies are used).

## Timing
- Reset values:
  - state IDLE, counter 0.
  - `readData`=0.
  - `sramWeN`=1, `sramOeN`=1, `sramCeN`=1.
  - `sramAddr`=0, `sramDq` high-Z.
  - `ready`=1 when no request is applied.
- Request sampled in IDLE at edge 0 → LO for WAIT_CYCLES cycles → HI for WAIT_CYCLES cycles → DONE.
- Total latency: 2·WAIT_CYCLES+1 cycles with `ready`=0, then 1 cycle `ready`=1. Default: 7 frozen cycles plus 1 ready cycle.
- `readData` is valid in the DONE cycle and holds afterwards.
- Back-to-back requests: a new request seen in IDLE, the cycle after DONE, starts a fresh access. There is no zero-gap pipelining.
- Reset mid-access: immediate return to IDLE with SRAM controls deasserted. A partial write may have modified one half-word. `readData` is cleared.

## Configuration
- `SRAM_ADDR_OFFSET_EN` defined: `ea = address - 32'd1024`. Data memory is mapped at byte address 1024 upward.
- Not defined: `ea = address` unmodified.

## Test plan
- Reset asserted mid-LO of a write → next cycle: IDLE, `sramWeN`=1, `sramCeN`=1, `readData`=0, `ready`=1 with no request.
- Store `writeData`=0xDEADBEEF to `address`=0x408 with offset enabled → SRAM half-address 4 gets 0xBEEF and half-address 5 gets 0xDEAD; `ready`=0 for 7 cycles, then high for 1.
- Load from the same address → `readData`=0xDEADBEEF in the DONE cycle; `sramOeN`=0 and `sramDq` undriven by the block during LO/HI.
- Load followed immediately by store to 0x40C of 0x12345678, then load 0x408 → `readData` stays 0xDEADBEEF through the store, second load returns 0xDEADBEEF, and a load of 0x40C returns 0x12345678.
- `wrEn`=`rdEn`=1 together → write performed, `readData` unchanged.
- `WAIT_CYCLES`=1 → each access completes with `ready` low for exactly 3 cycles.
